// File: rtl/req_arbiter4.sv
// req_arbiter4: four-requester arbiter with hold-until-release and hold timeout.
// Define RR_ARB_PRIORITY_EN for round-robin selection; fixed priority otherwise.
`timescale 1ns/1ps
module req_arbiter4 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gs,
  output logic       idle,
  output logic       timeout
);

  localparam int unsigned CW = $clog2(MAX_HOLD);
  localparam logic [CW-1:0] HOLD_LIM = CW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_RELEASE
  } state_t;

  state_t        state_q;
  logic [3:0]    gnt_q;
  logic [1:0]    id_q;
  logic          gs_q;
  logic          idle_q;
  logic          to_q;
  logic [CW-1:0] hold_q;
  logic [3:0]    mask_q;
  logic [3:0]    mask_d;
  logic [3:0]    elig;
  logic [1:0]    win_id;
  logic          own_req;
  logic          revoke;
  logic          idle_d;
`ifdef RR_ARB_PRIORITY_EN
  logic [1:0]    last_q;
  logic [1:0]    rr_idx;
`endif

  assign gnt     = gnt_q;
  assign gnt_id  = id_q;
  assign gs      = gs_q;
  assign idle    = idle_q;
  assign timeout = to_q;

  // Eligibility, owner status, hold-limit revoke and lockout next state.
  always_comb begin
    elig    = req & ~mask_q;
    own_req = req[id_q];
    revoke  = (state_q == S_GRANT) && en && own_req && (hold_q == HOLD_LIM);
    mask_d  = (mask_q & req) | (revoke ? gnt_q : 4'b0000);
    idle_d  = en && !(|elig);
  end

`ifdef RR_ARB_PRIORITY_EN
  // Round-robin: first eligible index after the last owner, wrapping.
  always_comb begin
    win_id = 2'd0;
    rr_idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      rr_idx = last_q + 2'(k + 1);
      if (elig[rr_idx]) win_id = rr_idx;
    end
  end
`else
  // Fixed priority: highest eligible index wins.
  always_comb begin
    win_id = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (elig[k]) win_id = 2'(k);
    end
  end
`endif

  // Arbiter FSM with registered outputs and lockout mask.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      gnt_q   <= 4'b0000;
      id_q    <= 2'd0;
      gs_q    <= 1'b0;
      idle_q  <= 1'b0;
      to_q    <= 1'b0;
      hold_q  <= '0;
      mask_q  <= 4'b0000;
`ifdef RR_ARB_PRIORITY_EN
      last_q  <= 2'd3;
`endif
    end else begin
      mask_q <= mask_d;
      to_q   <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (en && (|elig)) begin
            gnt_q   <= 4'b0001 << win_id;
            id_q    <= win_id;
            gs_q    <= 1'b1;
            idle_q  <= 1'b0;
            hold_q  <= '0;
            state_q <= S_GRANT;
`ifdef RR_ARB_PRIORITY_EN
            last_q  <= win_id;
`endif
          end else begin
            gnt_q  <= 4'b0000;
            id_q   <= 2'd0;
            gs_q   <= 1'b0;
            idle_q <= idle_d;
          end
        end
        S_GRANT: begin
          if (!en || !own_req || revoke) begin
            gnt_q   <= 4'b0000;
            id_q    <= 2'd0;
            gs_q    <= 1'b0;
            idle_q  <= idle_d;
            to_q    <= revoke;
            state_q <= S_RELEASE;
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        S_RELEASE: begin
          gnt_q   <= 4'b0000;
          id_q    <= 2'd0;
          gs_q    <= 1'b0;
          idle_q  <= idle_d;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_req_arbiter4.sv
// tb_req_arbiter4: scoreboard bench for req_arbiter4 (MAX_HOLD=4).
// Rows hold {reset,en,req} stimulus and the outputs expected after the edge.
`timescale 1ns/1ps
module tb_req_arbiter4;

  typedef logic [14:0] row_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gs;
  logic       idle;
  logic       timeout;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];

  req_arbiter4 #(.MAX_HOLD(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .req    (req),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .gs     (gs),
    .idle   (idle),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] obs();
    return {gnt, gnt_id, gs, idle, timeout};
  endfunction

  function automatic row_t r(input logic rs, input logic e,
                             input logic [3:0] q, input logic [3:0] g,
                             input logic [1:0] id, input logic i,
                             input logic t);
    return {rs, e, q, g, id, |g, i, t};
  endfunction

  task automatic test_reset();
    row_t t[$];
    logic [8:0] got, want;
    t = '{r(1'b1, 1'b0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0),
          r(1'b1, 1'b1, 4'hF, 4'h0, 2'd0, 1'b0, 1'b0)};
    foreach (t[k]) begin
      {reset, en, req} = t[k][14:9];
      exp_q.push_back(t[k][8:0]);
      @(posedge clk); #1;
      got = obs();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset[%0d] got %b want %b", k, got, want);
      end
    end
  endtask

  task automatic test_priority();
    row_t t[$];
    logic [8:0] got, want;
`ifdef RR_ARB_PRIORITY_EN
    t = '{r(1'b0, 1'b1, 4'b1010, 4'b0010, 2'd1, 1'b0, 1'b0),
          r(1'b0, 1'b1, 4'b1000, 4'b0000, 2'd0, 1'b0, 1'b0),
          r(1'b0, 1'b1, 4'b1000, 4'b0000, 2'd0, 1'b0, 1'b0),
          r(1'b0, 1'b1, 4'b1000, 4'b1000, 2'd3, 1'b0, 1'b0),
          r(1'b0, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0),
          r(1'b0, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0),
          r(1'b0, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0)};
`else
    t = '{r(1'b0, 1'b1, 4'b1010, 4'b1000, 2'd3, 1'b0, 1'b0),
          r(1'b0, 1'b1, 4'b0010, 4'b0000, 2'd0, 1'b0, 1'b0),
          r(1'b0, 1'b1, 4'b0010, 4'b0000, 2'd0, 1'b0, 1'b0),
          r(1'b0, 1'b1, 4'b0010, 4'b0010, 2'd1, 1'b0, 1'b0),
          r(1'b0, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0),
          r(1'b0, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0),
          r(1'b0, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0)};
`endif
    foreach (t[k]) begin
      {reset, en, req} = t[k][14:9];
      exp_q.push_back(t[k][8:0]);
      @(posedge clk); #1;
      got = obs();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL priority[%0d] got %b want %b", k, got, want);
      end
    end
  endtask

  task automatic test_timeout();
    row_t t[$];
    logic [8:0] got, want;
    t = '{r(1'b0, 1'b1, 4'b0001, 4'b0001, 2'd0, 1'b0, 1'b0),
          r(1'b0, 1'b1, 4'b0001, 4'b0001, 2'd0, 1'b0, 1'b0),
          r(1'b0, 1'b1, 4'b0001, 4'b0001, 2'd0, 1'b0, 1'b0),
          r(1'b0, 1'b1, 4'b0001, 4'b0001, 2'd0, 1'b0, 1'b0),
          r(1'b0, 1'b1, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b1),
          r(1'b0, 1'b1, 4'b0001, 4'b0000, 2'd0, 1'b1, 1'b0),
          r(1'b0, 1'b1, 4'b0001, 4'b0000, 2'd0, 1'b1, 1'b0),
          r(1'b0, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0),
          r(1'b0, 1'b1, 4'b0001, 4'b0001, 2'd0, 1'b0, 1'b0),
          r(1'b0, 1'b1, 4'b0001, 4'b0001, 2'd0, 1'b0, 1'b0),
          r(1'b0, 1'b1, 4'b0001, 4'b0001, 2'd0, 1'b0, 1'b0),
          r(1'b0, 1'b1, 4'b0001, 4'b0001, 2'd0, 1'b0, 1'b0),
          r(1'b0, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0),
          r(1'b0, 1'b1, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0),
          r(1'b0, 1'b1, 4'b0001, 4'b0001, 2'd0, 1'b0, 1'b0),
          r(1'b0, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0),
          r(1'b0, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0)};
    foreach (t[k]) begin
      {reset, en, req} = t[k][14:9];
      exp_q.push_back(t[k][8:0]);
      @(posedge clk); #1;
      got = obs();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL timeout[%0d] got %b want %b", k, got, want);
      end
    end
  endtask

  task automatic test_en_drop();
    row_t t[$];
    logic [8:0] got, want;
    t = '{r(1'b0, 1'b1, 4'b0100, 4'b0100, 2'd2, 1'b0, 1'b0),
          r(1'b0, 1'b1, 4'b0100, 4'b0100, 2'd2, 1'b0, 1'b0),
          r(1'b0, 1'b0, 4'b0100, 4'b0000, 2'd0, 1'b0, 1'b0),
          r(1'b0, 1'b0, 4'b0100, 4'b0000, 2'd0, 1'b0, 1'b0),
          r(1'b0, 1'b0, 4'b0100, 4'b0000, 2'd0, 1'b0, 1'b0),
          r(1'b0, 1'b1, 4'b0100, 4'b0100, 2'd2, 1'b0, 1'b0),
          r(1'b0, 1'b1, 4'b0100, 4'b0100, 2'd2, 1'b0, 1'b0),
          r(1'b0, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0),
          r(1'b0, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0),
          r(1'b0, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0)};
    foreach (t[k]) begin
      {reset, en, req} = t[k][14:9];
      exp_q.push_back(t[k][8:0]);
      @(posedge clk); #1;
      got = obs();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL en_drop[%0d] got %b want %b", k, got, want);
      end
    end
  endtask

  task automatic test_reset_mid();
    row_t t[$];
    logic [8:0] got, want;
    t = '{r(1'b0, 1'b1, 4'b0100, 4'b0100, 2'd2, 1'b0, 1'b0),
          r(1'b0, 1'b1, 4'b0100, 4'b0100, 2'd2, 1'b0, 1'b0),
          r(1'b1, 1'b1, 4'b0100, 4'b0000, 2'd0, 1'b0, 1'b0),
          r(1'b0, 1'b1, 4'b0100, 4'b0100, 2'd2, 1'b0, 1'b0),
          r(1'b0, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0),
          r(1'b0, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0)};
    foreach (t[k]) begin
      {reset, en, req} = t[k][14:9];
      exp_q.push_back(t[k][8:0]);
      @(posedge clk); #1;
      got = obs();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset_mid[%0d] got %b want %b", k, got, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    int ord[5];
    row_t t[$];
    logic [8:0] got, want;
    logic [3:0] oh;
`ifdef RR_ARB_PRIORITY_EN
    ord = '{0, 1, 2, 3, 0};
`else
    ord = '{3, 3, 3, 3, 3};
`endif
    t.push_back(r(1'b1, 1'b1, 4'hF, 4'h0, 2'd0, 1'b0, 1'b0));
    for (int n = 0; n < 5; n++) begin
      oh = 4'b0001 << ord[n];
      t.push_back(r(1'b0, 1'b1, 4'hF, oh, 2'(ord[n]), 1'b0, 1'b0));
      t.push_back(r(1'b0, 1'b1, 4'hF, oh, 2'(ord[n]), 1'b0, 1'b0));
      t.push_back(r(1'b0, 1'b1, 4'hF & ~oh, 4'h0, 2'd0, 1'b0, 1'b0));
      t.push_back(r(1'b0, 1'b1, 4'hF, 4'h0, 2'd0, 1'b0, 1'b0));
    end
    foreach (t[k]) begin
      {reset, en, req} = t[k][14:9];
      exp_q.push_back(t[k][8:0]);
      @(posedge clk); #1;
      got = obs();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL back_to_back[%0d] got %b want %b", k, got, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_timeout();
    test_en_drop();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
